// File: rtl/d_shift_reg.sv
// Universal shift register with hold, shift left, shift right and parallel load; counts shifts and pulses frame_done on every WIDTH-th shift.
// Latency: q, bit_cnt and frame_done change one clk edge after a qualifying edge; qb and sout are combinational.
// Backpressure: none; en=0 freezes all state. Defining D_SHIFT_REG_PARITY_EN adds a registered parity output.
module d_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       data,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qb,
    output logic                       sout,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt,
`ifdef D_SHIFT_REG_PARITY_EN
    output logic                       parity,
`endif
    output logic                       frame_done
);

    localparam int             CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    mode_e           mode_sel;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fd_q, fd_d;
    logic             shift;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        fd_d  = 1'b0;
        shift = 1'b0;
        if (en) begin
            case (mode_sel)
                MODE_SHL: begin
                    q_d   = {q_q[WIDTH-2:0], data};
                    shift = 1'b1;
                end
                MODE_SHR: begin
                    q_d   = {data, q_q[WIDTH-1:1]};
                    shift = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = din;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end
        // Direction does not matter for framing: any shift advances the count.
        if (shift) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                fd_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q   <= RESET_VAL;
            cnt_q <= '0;
            fd_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
            fd_q  <= fd_d;
        end
    end

`ifdef D_SHIFT_REG_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= ^RESET_VAL;
        end else begin
            parity_q <= ^q_d;
        end
    end

    assign parity = parity_q;
`endif

    assign q          = q_q;
    assign qb         = ~q_q;
    assign bit_cnt    = cnt_q;
    assign frame_done = fd_q;
    assign sout       = (mode_sel == MODE_SHL) ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: tb/tb_d_shift_reg.sv
// Scoreboard bench for d_shift_reg (WIDTH=8, RESET_VAL=0); the driver queues expected results, the monitor checks them.
module tb_d_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       data = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] q, qb;
    logic       sout;
    logic [2:0] bit_cnt;
    logic       frame_done;
`ifdef D_SHIFT_REG_PARITY_EN
    logic       parity;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit         is_sout;
        logic [7:0] q;
        logic [2:0] cnt;
        logic       fd;
        logic       sout;
    } exp_t;

    exp_t exp_q[$];

    d_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .mode(mode),
        .data(data),
        .din(din),
        .q(q),
        .qb(qb),
        .sout(sout),
        .bit_cnt(bit_cnt),
`ifdef D_SHIFT_REG_PARITY_EN
        .parity(parity),
`endif
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are stable 1 time unit after a falling clk edge or a reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge rst);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.is_sout) begin
                    chk("sout", {31'b0, sout}, {31'b0, e.sout});
                end else begin
                    chk("q", {24'b0, q}, {24'b0, e.q});
                    chk("qb", {24'b0, qb}, {24'b0, ~e.q});
                    chk("bit_cnt", {29'b0, bit_cnt}, {29'b0, e.cnt});
                    chk("frame_done", {31'b0, frame_done}, {31'b0, e.fd});
`ifdef D_SHIFT_REG_PARITY_EN
                    chk("parity", {31'b0, parity}, {31'b0, ^e.q});
`endif
                end
            end
        end
    end

    task automatic push_state(input logic [7:0] eq, input logic [2:0] ec, input logic efd);
        exp_t e;
        e.is_sout = 1'b0;
        e.q       = eq;
        e.cnt     = ec;
        e.fd      = efd;
        e.sout    = 1'b0;
        exp_q.push_back(e);
    endtask

    // es < 0 skips the pre-edge sout check.
    task automatic step(input logic e, input logic [1:0] m, input logic d, input logic [7:0] di,
                        input int es, input logic [7:0] eq, input logic [2:0] ec, input logic efd);
        exp_t s;
        en   = e;
        mode = m;
        data = d;
        din  = di;
        if (es >= 0) begin
            s.is_sout = 1'b1;
            s.q       = 8'h00;
            s.cnt     = 3'd0;
            s.fd      = 1'b0;
            s.sout    = (es != 0);
            exp_q.push_back(s);
        end
        @(posedge clk);
        #1;
        push_state(eq, ec, efd);
    endtask

    initial begin
        logic [7:0] ser;
        logic [7:0] shl_q [8];
        #1;
        push_state(8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;

        step(1, 2'b11, 0, 8'hA5, -1, 8'hA5, 3'd0, 0);
        step(1, 2'b10, 1, 8'h00,  1, 8'hD2, 3'd1, 0);
        step(1, 2'b11, 0, 8'h00, -1, 8'h00, 3'd0, 0);

        // Serial frame 1,0,1,0,0,1,1,0 shifted left; pulse only on the 8th edge.
        ser = 8'b10100110;
        shl_q = '{8'h01, 8'h02, 8'h05, 8'h0A, 8'h14, 8'h29, 8'h53, 8'hA6};
        for (int i = 0; i < 8; i++) begin
            step(1, 2'b01, ser[7-i], 8'h00, 0, shl_q[i], 3'((i + 1) % 8), (i == 7));
        end
        step(1, 2'b00, 0, 8'h00,  0, 8'hA6, 3'd0, 0);
        step(1, 2'b01, 1, 8'h00,  1, 8'h4D, 3'd1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 2'b01, 1, 8'hFF, -1, 8'h4D, 3'd1, 0);
        end

        // Mixed directions keep counting.
        step(1, 2'b10, 0, 8'h00,  1, 8'h26, 3'd2, 0);
        step(1, 2'b01, 1, 8'h00,  0, 8'h4D, 3'd3, 0);
        step(1, 2'b10, 1, 8'h00,  1, 8'hA6, 3'd4, 0);
        step(1, 2'b01, 0, 8'h00,  1, 8'h4C, 3'd5, 0);

        // Asynchronous reset between edges, checked before the next rising edge.
        @(negedge clk);
        #2;
        push_state(8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        step(1, 2'b01, 1, 8'h00, -1, 8'h00, 3'd0, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;

        step(1, 2'b01, 1, 8'h00, -1, 8'h01, 3'd1, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 2'b10, 0, 8'h00, -1, 8'h00, 3'(i + 2), 0);
        end
        step(1, 2'b10, 1, 8'h00, -1, 8'h80, 3'd0, 1);
        step(1, 2'b11, 0, 8'h3C,  0, 8'h3C, 3'd0, 0);
        step(1, 2'b01, 1, 8'h00,  0, 8'h79, 3'd1, 0);
        step(1, 2'b01, 1, 8'h00,  0, 8'hF3, 3'd2, 0);
        step(1, 2'b11, 0, 8'h5A,  1, 8'h5A, 3'd0, 0);
        step(1, 2'b00, 1, 8'h00,  0, 8'h5A, 3'd0, 0);
`ifdef D_SHIFT_REG_PARITY_EN
        step(1, 2'b11, 0, 8'h07, -1, 8'h07, 3'd0, 0);
        step(1, 2'b01, 0, 8'h00, -1, 8'h0E, 3'd1, 0);
        step(1, 2'b11, 0, 8'h03, -1, 8'h03, 3'd0, 0);
`endif

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expected results left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
